// File: rtl/fpu_fma_sequencer.sv
// fpu_fma_sequencer
// Multi-cycle controller for the shared single-precision FMA datapath. It
// accepts one operation at a time, walks it through multiply, addend
// alignment, add, normalize and round (skipping the stages an op does not
// need), drives one-hot stage enables and returns a tagged response.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready      issue handshake; req_op, req_tag, req_special payload
//   flush                    abort the operation in flight (no response)
//   op_q                     latched op_type
//   mul_en..round_en         one-hot datapath stage enables
//   resp_valid/resp_ready    response handshake; resp_tag, resp_bypass, resp_illegal
//   busy                     an operation is in flight
//   done_count               completed responses, wraps
module fpu_fma_sequencer #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_special,
    input  logic             flush,
    output logic [2:0]       op_q,
    output logic             mul_en,
    output logic             align_en,
    output logic             add_en,
    output logic             norm_en,
    output logic             round_en,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_bypass,
    output logic             resp_illegal,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);

    typedef enum logic [2:0] {
        StIdle,
        StMul,
        StAlign,
        StAdd,
        StNorm,
        StRound,
        StDone
    } state_t;

    localparam logic [2:0] OpAdd   = 3'b000;
    localparam logic [2:0] OpSub   = 3'b001;
    localparam logic [2:0] OpMul   = 3'b010;
    localparam logic [2:0] OpIll   = 3'b111;
    // Counter is loaded on MUL entry and the state exits when it hits zero,
    // so MUL lasts exactly MUL_CYCLES cycles.
    localparam logic [2:0] MulLoad = 3'(MUL_CYCLES - 1);

    state_t     state;
    logic [2:0] mul_cnt;
    logic       accept;
    logic       handshake;
    logic       req_bypass;

    // req_ready depends only on state, flush and rst, never on req_valid.
    assign req_ready  = (state == StIdle) & ~flush & ~rst;
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state == StDone) & ~flush;
    assign handshake  = resp_valid & resp_ready;
    assign req_bypass = req_special | (req_op == OpIll);

    assign mul_en   = (state == StMul)   & ~flush;
    assign align_en = (state == StAlign) & ~flush;
    assign add_en   = (state == StAdd)   & ~flush;
    assign norm_en  = (state == StNorm)  & ~flush;
    assign round_en = (state == StRound) & ~flush;
    assign busy     = (state != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            mul_cnt      <= 3'd0;
            op_q         <= 3'd0;
            resp_tag     <= '0;
            resp_bypass  <= 1'b0;
            resp_illegal <= 1'b0;
            done_count   <= '0;
        end else begin
            // Response fields hold until the next acceptance.
            if (accept) begin
                op_q         <= req_op;
                resp_tag     <= req_tag;
                resp_bypass  <= req_bypass;
                resp_illegal <= (req_op == OpIll);
            end

            if (handshake) begin
                done_count <= done_count + CNT_W'(1);
            end

            if (flush && (state != StIdle)) begin
                state <= StIdle;
            end else begin
                case (state)
                    StIdle: begin
                        if (accept) begin
                            if (req_bypass) begin
                                state <= StDone;
                            end else if ((req_op == OpAdd) || (req_op == OpSub)) begin
                                state <= StAlign;
                            end else begin
                                state   <= StMul;
                                mul_cnt <= MulLoad;
                            end
                        end
                    end
                    StMul: begin
                        if (mul_cnt == 3'd0) begin
                            state <= (op_q == OpMul) ? StNorm : StAlign;
                        end else begin
                            mul_cnt <= mul_cnt - 3'd1;
                        end
                    end
                    StAlign: state <= StAdd;
                    StAdd:   state <= StNorm;
                    StNorm:  state <= StRound;
                    StRound: state <= StDone;
                    StDone: begin
                        if (handshake) begin
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fpu_fma_sequencer.sv
module tb_fpu_fma_sequencer;

    localparam int M  = 2;
    localparam int TW = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [TW-1:0] req_tag;
    logic          req_special;
    logic          flush;
    logic [2:0]    op_q;
    logic          mul_en, align_en, add_en, norm_en, round_en;
    logic          resp_valid;
    logic          resp_ready;
    logic [TW-1:0] resp_tag;
    logic          resp_bypass;
    logic          resp_illegal;
    logic          busy;
    logic [CW-1:0] done_count;

    int errors = 0;
    int checks = 0;
    int model_count = 0;

    fpu_fma_sequencer #(
        .MUL_CYCLES(M),
        .TAG_W     (TW),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_tag     (req_tag),
        .req_special (req_special),
        .flush       (flush),
        .op_q        (op_q),
        .mul_en      (mul_en),
        .align_en    (align_en),
        .add_en      (add_en),
        .norm_en     (norm_en),
        .round_en    (round_en),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_tag    (resp_tag),
        .resp_bypass (resp_bypass),
        .resp_illegal(resp_illegal),
        .busy        (busy),
        .done_count  (done_count)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] en_vec();
        return {mul_en, align_en, add_en, norm_en, round_en};
    endfunction

    // Reference: cycles from acceptance to first resp_valid.
    function automatic int latency(input logic [2:0] op, input logic special);
        if (special || op == 3'd7) return 1;
        if (op <= 3'd1) return 5;
        if (op == 3'd2) return M + 3;
        return M + 5;
    endfunction

    // Reference: expected {mul,align,add,norm,round} in cycle k (k >= 1) after acceptance.
    function automatic logic [4:0] exp_en(input logic [2:0] op, input logic special, input int k);
        int mul_len;
        int j;
        if (special || op == 3'd7) return 5'b00000;
        mul_len = (op <= 3'd1) ? 0 : M;
        if (k <= mul_len) return 5'b10000;
        j = k - mul_len;
        if (op == 3'd2) begin
            if (j == 1) return 5'b00010;
            if (j == 2) return 5'b00001;
            return 5'b00000;
        end
        case (j)
            1: return 5'b01000;
            2: return 5'b00100;
            3: return 5'b00010;
            4: return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    // Present a request at a negedge; returns after the acceptance posedge (+1).
    task automatic accept_op(input logic [2:0] op, input logic [TW-1:0] tag, input logic special);
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
        end
        req_valid   = 1'b1;
        req_op      = op;
        req_tag     = tag;
        req_special = special;
        @(posedge clk);
        #1;
        // Scramble the request bus to prove the DUT latched its copy.
        req_valid   = 1'b0;
        req_special = 1'b0;
        req_op      = 3'($urandom);
        req_tag     = TW'($urandom);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [TW-1:0] tag,
                          input logic special, input int hold);
        int lat;
        lat = latency(op, special);
        accept_op(op, tag, special);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            checks++;
            if (en_vec() !== exp_en(op, special, k) || resp_valid !== 1'b0 ||
                busy !== 1'b1 || req_ready !== 1'b0 || op_q !== op) begin
                errors++;
                $display("FAIL stage op=%0d cyc=%0d: en=%b rv=%b busy=%b rdy=%b op_q=%0d required en=%b rv=0 busy=1 rdy=0 op_q=%0d",
                         op, k, en_vec(), resp_valid, busy, req_ready, op_q,
                         exp_en(op, special, k), op);
            end
        end
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_tag !== tag || en_vec() !== 5'b0 ||
                resp_bypass !== (special || op == 3'd7) || resp_illegal !== (op == 3'd7) ||
                req_ready !== 1'b0) begin
                errors++;
                $display("FAIL resp op=%0d cyc=%0d: rv=%b tag=%h byp=%b ill=%b en=%b rdy=%b required rv=1 tag=%h byp=%b ill=%b en=0 rdy=0",
                         op, lat + h, resp_valid, resp_tag, resp_bypass, resp_illegal,
                         en_vec(), req_ready, tag, (special || op == 3'd7), (op == 3'd7));
            end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        model_count = (model_count + 1) % (1 << CW);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0 ||
            done_count !== CW'(model_count)) begin
            errors++;
            $display("FAIL after_hs op=%0d: rdy=%b busy=%b rv=%b cnt=%0d required rdy=1 busy=0 rv=0 cnt=%0d",
                     op, req_ready, busy, resp_valid, done_count, model_count);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (en_vec() !== 5'b0 || resp_valid !== 1'b0 || resp_tag !== '0 ||
            resp_bypass !== 1'b0 || resp_illegal !== 1'b0 || op_q !== 3'd0 ||
            busy !== 1'b0 || done_count !== '0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s: en=%b rv=%b tag=%h byp=%b ill=%b op_q=%0d busy=%b cnt=%0d rdy=%b required all 0",
                     name, en_vec(), resp_valid, resp_tag, resp_bypass, resp_illegal,
                     op_q, busy, done_count, req_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: req_ready=%b required 1", req_ready);
        end
        model_count = 0;
    endtask

    task automatic test_fma();
        run_op(3'd3, 5'h0A, 1'b0, 0);
    endtask

    task automatic test_mul_add();
        run_op(3'd2, 5'h11, 1'b0, 0);
        run_op(3'd0, 5'h12, 1'b0, 0);
        run_op(3'd1, 5'h13, 1'b0, 0);
    endtask

    task automatic test_bypass();
        run_op(3'd6, 5'h1C, 1'b1, 0);
        run_op(3'd7, 5'h07, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        run_op(3'd4, 5'h15, 1'b0, 10);
    endtask

    task automatic test_flush();
        // Flush an FMA in cycle 3 (ALIGN).
        accept_op(3'd3, 5'h09, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        checks++;
        if (en_vec() !== 5'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_align: en=%b rv=%b rdy=%b required en=0 rv=0 rdy=0",
                     en_vec(), resp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 ||
            done_count !== CW'(model_count)) begin
            errors++;
            $display("FAIL flush_idle: busy=%b rdy=%b rv=%b cnt=%0d required busy=0 rdy=1 rv=0 cnt=%0d",
                     busy, req_ready, resp_valid, done_count, model_count);
        end
        // Flush in DONE with resp_ready high is not a handshake.
        accept_op(3'd5, 5'h03, 1'b1);
        @(negedge clk);
        flush      = 1'b1;
        resp_ready = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_done_rv: resp_valid=%b required 0", resp_valid);
        end
        @(posedge clk);
        #1;
        flush      = 1'b0;
        resp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || done_count !== CW'(model_count)) begin
            errors++;
            $display("FAIL flush_done: busy=%b rv=%b cnt=%0d required busy=0 rv=0 cnt=%0d",
                     busy, resp_valid, done_count, model_count);
        end
    endtask

    task automatic test_reset_mid();
        accept_op(3'd3, 5'h1F, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid_mul");
        model_count = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: rv=%b busy=%b rdy=%b required rv=0 busy=0 rdy=1",
                     resp_valid, busy, req_ready);
        end
    endtask

    // Random ops until the counter reaches all-ones, then one more to wrap.
    task automatic test_random_wrap();
        logic [2:0] op;
        logic       sp;
        while (model_count != (1 << CW) - 1) begin
            op = 3'($urandom);
            sp = ($urandom_range(0, 3) == 0);
            run_op(op, TW'($urandom), sp, $urandom_range(0, 3));
        end
        checks++;
        if (done_count !== {CW{1'b1}}) begin
            errors++;
            $display("FAIL preload: done_count=%0d required %0d", done_count, (1 << CW) - 1);
        end
        run_op(3'($urandom), TW'($urandom), 1'b0, 0);
        checks++;
        if (done_count !== '0) begin
            errors++;
            $display("FAIL wrap: done_count=%0d required 0", done_count);
        end
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_op      = 3'd0;
        req_tag     = '0;
        req_special = 1'b0;
        flush       = 1'b0;
        resp_ready  = 1'b0;
        test_reset();
        test_fma();
        test_mul_add();
        test_bypass();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpu_fma_sequencer.md
# fpu_fma_sequencer

Multi-cycle controller that sequences the shared single-precision FMA datapath: multiply, addend alignment, add, normalize and round. It accepts one operation at a time from the issue stage over a valid/ready handshake and decodes the 3-bit FPU op_type to skip unused stages. It drives one-hot stage enables into the datapath and returns a tagged response over a second valid/ready handshake. It sits between the integer pipeline's FPU issue port and the FPU datapath registers.

## Interface
- MUL_CYCLES, 2, cycles the multiplier needs (legal 1..8)
- TAG_W, 5, width of request/response tag
- CNT_W, 16, width of completed-operation counter
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_op  in  3  op_type: 000 ADD, 001 SUB, 010 MUL, 011 FMA, 100 FMS, 101 FNMADD, 110 FNMSUB, 111 illegal
- req_tag  in  TAG_W  destination tag
- req_special  in  1  operand special case (NaN/Inf/zero) resolved by bypass logic
- flush  in  1  abort current operation
- op_q  out  3  latched op_type, valid while busy
- mul_en, align_en, add_en, norm_en, round_en  out  1 each  stage enables
- resp_valid  out  1  result ready
- resp_ready  in  1  consumer accepts
- resp_tag  out  TAG_W  latched tag
- resp_bypass  out  1  result comes from special-case bypass
- resp_illegal  out  1  op was 111
- busy  out  1  state != IDLE
- done_count  out  CNT_W  completed responses, wraps

## Operation
- States: IDLE, MUL, ALIGN, ADD, NORM, ROUND, DONE.
- req_ready = (state==IDLE) & ~flush & ~rst. Acceptance is req_valid & req_ready. On acceptance, latch req_op, req_tag, bypass flag and illegal flag.
- Next state from IDLE on acceptance:
  - req_special=1 or op=111 → DONE. Set bypass=1; illegal also set for 111.
  - ADD/SUB → ALIGN (no MUL).
  - All other ops → MUL.
- MUL: 3-bit counter loaded with MUL_CYCLES-1 on entry. State is held until the counter reaches 0, so MUL lasts exactly MUL_CYCLES cycles. It then goes to NORM for op MUL, or ALIGN for all other ops.
- ALIGN → ADD → NORM → ROUND → DONE. Each of these states lasts one cycle.
- Each stage enable = (state==that stage) & ~flush. Exactly one enable is high in any cycle; none are high in IDLE or DONE.
- DONE: resp_valid = ~flush. State is held until resp_valid & resp_ready, then goes to IDLE. done_count increments by 1 on that handshake and wraps from all-ones to 0.
- flush (any state except IDLE): next state is IDLE. No response is produced and done_count is unchanged. Flush in DONE with resp_ready=1 is not a handshake. Flush in IDLE blocks acceptance for that cycle.
- resp_tag, resp_bypass and resp_illegal hold their latched values until the next acceptance.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs 0: all enables, resp_valid, resp_tag, resp_bypass, resp_illegal, op_q, busy, done_count, req_ready (gated by rst). req_ready goes to 1 in the first cycle after rst deasserts.
  - Reset mid-operation aborts immediately with no response.
- Latency counts from the acceptance edge (cycle 0) to the first cycle resp_valid=1, with MUL_CYCLES=M:
  - FMA family: M+5.
  - MUL: M+3.
  - ADD/SUB: 5.
  - Bypass/illegal: 1.
- FMA, M=2: MUL in cycles 1-2, ALIGN 3, ADD 4, NORM 5, ROUND 6, resp_valid from cycle 7.
- No back-to-back acceptance: after the response handshake in cycle N, req_ready=1 in cycle N+1.
- resp_valid stays high and response fields stay stable while resp_ready=0, for unbounded backpressure.
- No combinational path from req_valid to req_ready. resp_valid depends combinationally only on state and flush.

## Test plan
- FMA (011), tag 5'h0A, M=2, resp_ready=1:
  - Enables are mul 2 cycles, align, add, norm, round, one cycle each, in that order.
  - resp_valid in cycle 7 with resp_tag=0x0A and bypass=0. done_count goes 0→1.
- MUL (010) then ADD (000):
  - MUL: align_en and add_en never assert; resp in cycle 5.
  - ADD: mul_en never asserts; resp 5 cycles after acceptance. req_ready is low while busy.
- req_special=1 with FNMSUB: resp_valid in cycle 1 with bypass=1 and no stage enable asserted. op 111: resp_illegal=1 and bypass=1.
- resp_ready held 0 for 10 cycles in DONE: resp_valid and resp_tag stay stable, and req_ready=0. Release gives one handshake and done_count +1.
- Flush in cycle 3 (ALIGN) of an FMA: align_en=0 in that cycle, state is IDLE in cycle 4 with req_ready=1, no resp_valid, and done_count unchanged. Repeat the flush in DONE with resp_ready=1: no count increment.
- rst asserted during MUL: all outputs 0 asynchronously. Preload done_count to all-ones and complete one op: it wraps to 0.
